alu_operand_loader: RTL
=======================

Name: alu_operand_loader

Overview:
Input-side sequencer for the ALU lab board. It assembles 32-bit operands A and B and the 3-bit ALU control from 4-bit switch nibbles on KEY presses. It issues the operation to the ALU over a valid/ready handshake, then captures the returned result and flags for the HEX display path. It sits between the board I/O (KEY/SW) and the ALU datapath.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4
TIMEOUT, 1024, maximum clk cycles to wait for res_valid after issue

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous reset, active-low
enter  input  1  level, active-high (already inverted and synchronized KEY[0])
go  input  1  level, active-high (already inverted and synchronized KEY[1])
sel  input  2  load target: 00 busA, 01 busB, 10 control, 11 clear all
nibble  input  4  operand nibble (SW[3:0])
ctrl_in  input  3  ALU control value (SW[6:4])
busA  output  WIDTH  operand A to ALU
busB  output  WIDTH  operand B to ALU
control  output  3  ALU op select
op_valid  output  1  operation offered to ALU
op_ready  input  1  ALU accepts operation
res_valid  input  1  ALU result present (one-cycle pulse)
result  input  WIDTH  ALU result
flags  input  4  {z,v,c,n} from ALU
out_value  output  WIDTH  captured result for display
out_flags  output  4  captured {z,v,c,n}
done  output  1  one-cycle pulse on result capture
err  output  1  sticky timeout error
busy  output  1  high whenever state is not IDLE
cntA  output  4  nibbles loaded into A, 0..WIDTH/4, saturating
cntB  output  4  nibbles loaded into B, 0..WIDTH/4, saturating

Behaviour:
- Reset (reset_n low at a clk edge):
  - busA, busB, control, out_value, out_flags, cntA and cntB all 0.
  - op_valid, done, err and busy all 0; state IDLE.
  - Edge-detect history registers for enter and go reset to 1, so a key held through reset does not fire.
- Reset mid-operation aborts at once: state returns to IDLE and op_valid drops in the same cycle.
- Edge detect: enter_e = enter & ~enter_q; go_e = go & ~go_q. History registers update every cycle.
- States: IDLE, ISSUE, WAIT.
- IDLE, on enter_e:
  - sel=00: busA <= {busA[WIDTH-5:0], nibble}; cntA <= min(cntA+1, WIDTH/4).
  - sel=01: the same shift on busB and cntB.
  - sel=10: control <= ctrl_in.
  - sel=11: busA, busB, control, cntA and cntB <= 0.
  - Once more than WIDTH/4 nibbles are loaded, the most significant nibble is discarded; the count stays saturated.
- IDLE, on go_e:
  - Clear err; next state ISSUE.
  - If enter_e occurs in the same cycle, the load is applied first, so ISSUE presents the updated operands.
- ISSUE:
  - op_valid = 1.
  - The transfer occurs on the first clk edge with op_valid & op_ready; next state WAIT and op_valid goes 0.
  - op_valid is never withdrawn before the transfer.
- WAIT:
  - A wait counter starts at 0 on entry.
  - On res_valid: out_value <= result, out_flags <= flags, done = 1 for that single cycle, next state IDLE.
  - If the counter reaches TIMEOUT-1 without res_valid: err <= 1, out_value and out_flags unchanged, next state IDLE.
  - res_valid and timeout in the same cycle: the result wins and err stays 0.
- busA, busB and control are frozen while busy=1. enter_e and go_e outside IDLE are ignored; they are not queued.
- res_valid seen in IDLE or ISSUE is ignored.
- Latency:
  - go_e to op_valid: 1 cycle.
  - res_valid to out_value/done: 1 cycle, registered.

Test Plan:
- Load, issue, capture: reset, then sel=00 with nibbles 1,2,3,4 (4 enter presses) gives busA=0x00001234 and cntA=4. sel=01 with nibble F gives busB=0x0000000F. sel=10 with ctrl_in=3 gives control=3. go press then raises op_valid; with op_ready=1, the state moves to WAIT. res_valid with result=0x1243 and flags=0000 gives out_value=0x1243 and one done pulse.
- Overflow: 9 enter presses on A with nibbles 1..9 give busA=0x23456789 and cntA=8.
- Handshake stall and frozen operands: op_ready held 0 for 5 cycles keeps op_valid=1 and busA stable. An enter press during the stall leaves busA unchanged. op_ready=1 then completes the transfer.
- Timeout: with TIMEOUT=16, no res_valid gives err=1 and busy=0 exactly 16 cycles after entering WAIT, with out_value unchanged. The next go press clears err.
- Simultaneous events: enter and go rising in the same cycle with sel=00 and nibble=A give busA={old<<4 | A} presented in ISSUE. In a separate test, res_valid on the final timeout cycle captures the result with err=0.
- Reset behaviour: enter held high through reset release produces no load. Reset_n low during WAIT returns all outputs to 0 and state to IDLE on the next edge.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Input-side sequencer for the ALU lab board: builds operands A/B and the ALU
// control from switch nibbles, issues them over valid/ready, captures the result.
module alu_operand_loader #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enter,
  input  logic             go,
  input  logic [1:0]       sel,
  input  logic [3:0]       nibble,
  input  logic [2:0]       ctrl_in,
  output logic [WIDTH-1:0] busA,
  output logic [WIDTH-1:0] busB,
  output logic [2:0]       control,
  output logic             op_valid,
  input  logic             op_ready,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] result,
  input  logic [3:0]       flags,
  output logic [WIDTH-1:0] out_value,
  output logic [3:0]       out_flags,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [3:0]       cntA,
  output logic [3:0]       cntB,
  output logic [1:0]       state_dbg
);

  // Handshake: op_valid rises one cycle after a go press and stays high until
  // the first clk edge where op_valid & op_ready; that edge is the transfer.
  // res_valid is a one-cycle pulse honoured only while waiting for a result.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]    NIB_MAX  = 4'(WIDTH / 4);
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bus_a_q, bus_a_d;
  logic [WIDTH-1:0]  bus_b_q, bus_b_d;
  logic [2:0]        control_q, control_d;
  logic [3:0]        cnt_a_q, cnt_a_d;
  logic [3:0]        cnt_b_q, cnt_b_d;
  logic [WIDTH-1:0]  out_value_q, out_value_d;
  logic [3:0]        out_flags_q, out_flags_d;
  logic              op_valid_q, op_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              enter_hist_q, enter_hist_d;
  logic              go_hist_q, go_hist_d;
  logic              enter_e;
  logic              go_e;

  assign enter_e = enter & ~enter_hist_q;
  assign go_e    = go & ~go_hist_q;

  always_comb begin
    state_d      = state_q;
    bus_a_d      = bus_a_q;
    bus_b_d      = bus_b_q;
    control_d    = control_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;
    out_value_d  = out_value_q;
    out_flags_d  = out_flags_q;
    op_valid_d   = op_valid_q;
    done_d       = 1'b0;
    err_d        = err_q;
    busy_d       = busy_q;
    wait_cnt_d   = wait_cnt_q;
    enter_hist_d = enter;
    go_hist_d    = go;

    case (state_q)
      S_IDLE: begin
        // The load is evaluated before go so a same-cycle press is issued.
        if (enter_e) begin
          case (sel)
            2'b00: begin
              bus_a_d = {bus_a_q[WIDTH-5:0], nibble};
              cnt_a_d = (cnt_a_q < NIB_MAX) ? cnt_a_q + 4'd1 : NIB_MAX;
            end
            2'b01: begin
              bus_b_d = {bus_b_q[WIDTH-5:0], nibble};
              cnt_b_d = (cnt_b_q < NIB_MAX) ? cnt_b_q + 4'd1 : NIB_MAX;
            end
            2'b10: control_d = ctrl_in;
            2'b11: begin
              bus_a_d   = '0;
              bus_b_d   = '0;
              control_d = '0;
              cnt_a_d   = '0;
              cnt_b_d   = '0;
            end
          endcase
        end
        if (go_e) begin
          err_d      = 1'b0;
          state_d    = S_ISSUE;
          op_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      S_ISSUE: begin
        if (op_valid_q && op_ready) begin
          state_d    = S_WAIT;
          op_valid_d = 1'b0;
          wait_cnt_d = '0;
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + TW'(1);
        // A result arriving on the last allowed cycle beats the timeout.
        if (res_valid) begin
          out_value_d = result;
          out_flags_d = flags;
          done_d      = 1'b1;
          state_d     = S_IDLE;
          busy_d      = 1'b0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        op_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bus_a_q      <= '0;
      bus_b_q      <= '0;
      control_q    <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      out_value_q  <= '0;
      out_flags_q  <= '0;
      op_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      wait_cnt_q   <= '0;
      // History set high so a key held through reset does not register a press.
      enter_hist_q <= 1'b1;
      go_hist_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      bus_a_q      <= bus_a_d;
      bus_b_q      <= bus_b_d;
      control_q    <= control_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      out_value_q  <= out_value_d;
      out_flags_q  <= out_flags_d;
      op_valid_q   <= op_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      wait_cnt_q   <= wait_cnt_d;
      enter_hist_q <= enter_hist_d;
      go_hist_q    <= go_hist_d;
    end
  end

  assign busA      = bus_a_q;
  assign busB      = bus_b_q;
  assign control   = control_q;
  assign cntA      = cnt_a_q;
  assign cntB      = cnt_b_q;
  assign out_value = out_value_q;
  assign out_flags = out_flags_q;
  assign op_valid  = op_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule
